// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
package wb_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned RA_W_DEF  = 5;
    localparam int unsigned CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'b00,
        SRC_LOAD = 2'b01,
        SRC_PC4  = 2'b10,
        SRC_NONE = 2'b11
    } src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT_MEM
    } state_e;

endpackage

// File: rtl/wb_writer_if.sv
// Retire handshake plus data-memory response bundle feeding the writeback stage.
interface wb_writer_if
    import wb_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned RA_W = RA_W_DEF
);
    logic            in_valid;
    logic            in_ready;
    logic [RA_W-1:0] in_rd;
    src_e            in_src;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_alu;
    logic [XLEN-1:0] in_pc4;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output in_valid, in_rd, in_src, in_funct3, in_alu, in_pc4, mem_rvalid, mem_rdata,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_rd, in_src, in_funct3, in_alu, in_pc4, mem_rvalid, mem_rdata,
        output in_ready
    );
endinterface

// File: rtl/load_ext.sv
// Load-data lane select and sign/zero extension, plus illegal/misaligned detection.
module load_ext
    import wb_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data_c,
    output logic            bad_c
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[{addr, 3'b000} +: 8];
        half_v = word[{addr[1], 4'b0000} +: 16];
        data_c = '0;
        bad_c  = 1'b0;
        case (funct3)
            F3_LB:   data_c = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_LBU:  data_c = {{(XLEN-8){1'b0}}, byte_v};
            F3_LH: begin
                data_c = {{(XLEN-16){half_v[15]}}, half_v};
                bad_c  = addr[0];
            end
            F3_LHU: begin
                data_c = {{(XLEN-16){1'b0}}, half_v};
                bad_c  = addr[0];
            end
            F3_LW: begin
                data_c = word;
                bad_c  = (addr != 2'b00);
            end
            default: bad_c = 1'b1;
        endcase
    end
endmodule

// File: rtl/wb_writer.sv
// Writeback stage: selects the result source and issues one register-file write pulse per instruction.
module wb_writer
    import wb_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned RA_W  = RA_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_writer_if.slave       bus,
    output logic [RA_W-1:0]  rd,
    output logic [XLEN-1:0]  datawrite,
    output logic             ruwr,
    output logic             busy,
    output logic [CNT_W-1:0] instret,
    output logic [1:0]       err
);
    state_e           state_q, state_d;
    logic [RA_W-1:0]  rd_q, rd_d;
    logic [XLEN-1:0]  data_q, data_d;
    logic             ruwr_q, ruwr_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [1:0]       err_q, err_d;
    logic [RA_W-1:0]  ld_rd_q, ld_rd_d;
    logic [2:0]       ld_f3_q, ld_f3_d;
    logic [1:0]       ld_addr_q, ld_addr_d;

    logic             waiting;
    logic [2:0]       ext_f3;
    logic [1:0]       ext_addr;
    logic [XLEN-1:0]  ext_data;
    logic             ext_bad;

    // Checks legality of the incoming load while idle, extends the latched load while waiting.
    assign waiting  = (state_q == ST_WAIT_MEM);
    assign ext_f3   = waiting ? ld_f3_q   : bus.in_funct3;
    assign ext_addr = waiting ? ld_addr_q : bus.in_alu[1:0];

    load_ext #(.XLEN(XLEN)) u_load_ext (
        .funct3 (ext_f3),
        .addr   (ext_addr),
        .word   (bus.mem_rdata),
        .data_c (ext_data),
        .bad_c  (ext_bad)
    );

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        data_d    = data_q;
        ruwr_d    = 1'b0;
        instret_d = instret_q;
        err_d     = err_q;
        ld_rd_d   = ld_rd_q;
        ld_f3_d   = ld_f3_q;
        ld_addr_d = ld_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.mem_rvalid) err_d[1] = 1'b1;
                if (bus.in_valid) begin
                    case (bus.in_src)
                        SRC_ALU, SRC_PC4: begin
                            rd_d      = bus.in_rd;
                            data_d    = (bus.in_src == SRC_ALU) ? bus.in_alu : bus.in_pc4;
                            ruwr_d    = (bus.in_rd != '0);
                            instret_d = instret_q + CNT_W'(1);
                        end
                        SRC_NONE: instret_d = instret_q + CNT_W'(1);
                        SRC_LOAD: begin
                            if (ext_bad) begin
                                err_d[0] = 1'b1;
                            end else begin
                                ld_rd_d   = bus.in_rd;
                                ld_f3_d   = bus.in_funct3;
                                ld_addr_d = bus.in_alu[1:0];
                                state_d   = ST_WAIT_MEM;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_WAIT_MEM: begin
                if (bus.mem_rvalid) begin
                    rd_d      = ld_rd_q;
                    data_d    = ext_data;
                    ruwr_d    = (ld_rd_q != '0);
                    instret_d = instret_q + CNT_W'(1);
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d  = (state_d == ST_WAIT_MEM);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rd_q      <= '0;
            data_q    <= '0;
            ruwr_q    <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            instret_q <= '0;
            err_q     <= '0;
            ld_rd_q   <= '0;
            ld_f3_q   <= '0;
            ld_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            ruwr_q    <= ruwr_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            instret_q <= instret_d;
            err_q     <= err_d;
            ld_rd_q   <= ld_rd_d;
            ld_f3_q   <= ld_f3_d;
            ld_addr_q <= ld_addr_d;
        end
    end

    assign bus.in_ready = ready_q;
    assign rd           = rd_q;
    assign datawrite    = data_q;
    assign ruwr         = ruwr_q;
    assign busy         = busy_q;
    assign instret      = instret_q;
    assign err          = err_q;
endmodule
